audio_sample_packet_decoder: RTL and testbench
==============================================

AUDIO_SAMPLE_PACKET_DECODER -- requirements
Module: audio_sample_packet_decoder

Interface
REQ-001 SHALL have parameter CHANNEL_STATUS_LENGTH, default 192, frames per IEC 60958 channel-status block.
REQ-002 SHALL have ports: clk_packet  in  1  packet clock; reset_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: packet_valid  in  1  strobe, header/sub0 hold one received packet this cycle.
REQ-004 SHALL have ports: header  in  24  packet header bytes HB2..HB0; sub0  in  56  subpacket 0.
REQ-005 SHALL have ports: sample_valid  out  1  one-cycle pulse, new sample on outputs.
REQ-006 SHALL have ports: audio_sample_word  out  2x24  [0]=left, [1]=right PCM word.
REQ-007 SHALL have ports: valid_bit, user_data_bit, parity_error  out  2 each  per channel, [0]=left.
REQ-008 SHALL have ports: locked  out  1  block-sync state is LOCKED; sync_error  out  1  one-cycle pulse.
REQ-009 SHALL have ports: channel_status_left, channel_status_right  out  CHANNEL_STATUS_LENGTH each; channel_status_valid  out  1  one-cycle pulse.

Function
REQ-010 SHALL accept a packet only when packet_valid=1, header[7:0]=8'd2, header[12]=0 (2-channel layout) and header[8]=1; all other packets are ignored with no output change.
REQ-011 SHALL decode sub0: [23:0] left word, [47:24] right word, [48]/[49]/[50]/[51] V/U/C/P left, [52]/[53]/[54]/[55] V/U/C/P right; B flag = header[20].
REQ-012 SHALL register outputs one cycle after an accepted packet: sample_valid=1, words, valid_bit, user_data_bit updated; outputs hold between packets.
REQ-013 SHALL set parity_error[i]=1 when XOR of channel i word, V, U, C, P is 1 (even parity); sample still delivered.
REQ-014 SHALL implement states HUNT and LOCKED with a frame counter 0..CHANNEL_STATUS_LENGTH-1; locked=1 only in LOCKED.
REQ-015 HUNT: accepted packet with B=0 is delivered but not counted; B=1 stores C bits at index 0, counter<=1, goes LOCKED.
REQ-016 LOCKED, B=1 and counter!=0: sync_error pulse, partial block discarded, treated as frame 0 (store at 0, counter<=1).
REQ-017 LOCKED, B=0 and counter=0: sync_error pulse, goes HUNT, C bits discarded.
REQ-018 LOCKED, otherwise: store C bits at index counter; if counter=CHANNEL_STATUS_LENGTH-1, counter wraps to 0, else increments.
REQ-019 Frame with counter=CHANNEL_STATUS_LENGTH-1 SHALL complete the block: shadow registers copied to channel_status_left/right and channel_status_valid pulses in the same cycle as sample_valid.
REQ-020 channel_status_left/right SHALL hold the last complete block until the next completion; partial blocks never visible.
REQ-021 Ignored packets SHALL not advance counter nor affect state.

Reset
REQ-022 reset_n=0 SHALL asynchronously clear all outputs, counter and shadow registers to 0 and set state HUNT, including mid-block.
REQ-023 First accepted packet after reset_n release SHALL be processed per REQ-015.

Configuration
REQ-024 Macro AUDIO_CHANNEL_STATUS_EN defined: channel-status shadow, capture and channel_status_* outputs implemented per REQ-019/020.
REQ-025 AUDIO_CHANNEL_STATUS_EN undefined: no shadow storage; channel_status_left/right tied 0, channel_status_valid tied 0; sync FSM, counter, locked, sync_error unchanged.

Verification
REQ-026 Reset, then 192 packets, first B=1, left C bits = pattern 0xA5 repeated, right = 0x3C repeated -> locked=1 after packet 1, channel_status_valid pulse with packet 192, outputs equal patterns with bit n = frame n.
REQ-027 Packet words L=24'h123456, R=24'hABCDEF, V=U=0, P correct -> sample_valid one cycle later, words match, parity_error=2'b00; flip right P -> parity_error=2'b10.
REQ-028 LOCKED at counter 50, packet with B=1 -> sync_error pulse, counter restarts, no channel_status_valid until 192 frames later.
REQ-029 LOCKED, packet 193 with B=0 -> sync_error pulse, locked=0; packets with B=0 ignored for counting until next B=1.
REQ-030 header[7:0]=8'd1 or header[12]=1 with packet_valid=1 -> no sample_valid, counter unchanged.
REQ-031 reset_n asserted mid-block at frame 100 -> all outputs 0 immediately, locked=0; both macro settings exercised.

Source files
------------

// File: rtl/audio_sample_packet_decoder.sv
// Two-channel audio sample packet decoder with IEC 60958 block sync.
// Channel-status capture is built only when AUDIO_CHANNEL_STATUS_EN is defined.

module audio_sample_channel (
    input  logic [23:0] word,
    input  logic [3:0]  vucp,
    output logic        parity_error
);
    // Even parity over the word and V/U/C/P: any odd total is an error.
    assign parity_error = ^{word, vucp};
endmodule

module audio_sample_packet_decoder #(
    parameter int CHANNEL_STATUS_LENGTH = 192
) (
    input  logic                             clk_packet,
    input  logic                             reset_n,
    input  logic                             packet_valid,
    input  logic [23:0]                      header,
    input  logic [55:0]                      sub0,
    output logic                             sample_valid,
    output logic [1:0][23:0]                 audio_sample_word,
    output logic [1:0]                       valid_bit,
    output logic [1:0]                       user_data_bit,
    output logic [1:0]                       parity_error,
    output logic                             locked,
    output logic                             sync_error,
    output logic [CHANNEL_STATUS_LENGTH-1:0] channel_status_left,
    output logic [CHANNEL_STATUS_LENGTH-1:0] channel_status_right,
    output logic                             channel_status_valid
);
    localparam int CW = (CHANNEL_STATUS_LENGTH > 1) ? $clog2(CHANNEL_STATUS_LENGTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(CHANNEL_STATUS_LENGTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [CW-1:0]    count, count_nxt, store_idx;
    logic             accept, b_flag, store, complete, sync_nxt;
    logic [1:0][23:0] word_in;
    logic [1:0][3:0]  vucp_in;
    logic [1:0]       par_nxt, c_bit;

    logic unused_header;
    assign unused_header = ^{header[23:21], header[19:13], header[11:9]};

    assign accept = packet_valid && (header[7:0] == 8'd2) && !header[12] && header[8];
    assign b_flag = header[20];
    assign locked = (state == ST_LOCKED);

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        assign word_in[ch] = sub0[24*ch +: 24];
        assign vucp_in[ch] = sub0[48 + 4*ch +: 4];
        assign c_bit[ch]   = vucp_in[ch][2];
        audio_sample_channel u_ch (
            .word         (word_in[ch]),
            .vucp         (vucp_in[ch]),
            .parity_error (par_nxt[ch])
        );
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        store     = 1'b0;
        store_idx = '0;
        complete  = 1'b0;
        sync_nxt  = 1'b0;
        if (accept) begin
            if (state == ST_HUNT) begin
                if (b_flag) begin
                    store     = 1'b1;
                    count_nxt = ONE;
                    state_nxt = ST_LOCKED;
                end
            end else if (b_flag && count != '0) begin
                // Early block start: restart the block at this frame.
                sync_nxt  = 1'b1;
                store     = 1'b1;
                count_nxt = ONE;
            end else if (!b_flag && count == '0) begin
                sync_nxt  = 1'b1;
                state_nxt = ST_HUNT;
            end else begin
                store     = 1'b1;
                store_idx = count;
                complete  = (count == LAST);
                count_nxt = complete ? '0 : count + ONE;
            end
        end
    end

    always_ff @(posedge clk_packet or negedge reset_n) begin
        if (!reset_n) begin
            state             <= ST_HUNT;
            count             <= '0;
            sample_valid      <= 1'b0;
            sync_error        <= 1'b0;
            audio_sample_word <= '0;
            valid_bit         <= '0;
            user_data_bit     <= '0;
            parity_error      <= '0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            sample_valid <= accept;
            sync_error   <= sync_nxt;
            if (accept) begin
                audio_sample_word <= word_in;
                valid_bit         <= {vucp_in[1][0], vucp_in[0][0]};
                user_data_bit     <= {vucp_in[1][1], vucp_in[0][1]};
                parity_error      <= par_nxt;
            end
        end
    end

`ifdef AUDIO_CHANNEL_STATUS_EN
    logic [CHANNEL_STATUS_LENGTH-1:0] shadow_l, shadow_r, shadow_l_nxt, shadow_r_nxt;

    always_comb begin
        shadow_l_nxt = shadow_l;
        shadow_r_nxt = shadow_r;
        if (store) begin
            shadow_l_nxt[store_idx] = c_bit[0];
            shadow_r_nxt[store_idx] = c_bit[1];
        end
    end

    // The completing frame's own C bit is folded in before publishing.
    always_ff @(posedge clk_packet or negedge reset_n) begin
        if (!reset_n) begin
            shadow_l             <= '0;
            shadow_r             <= '0;
            channel_status_left  <= '0;
            channel_status_right <= '0;
            channel_status_valid <= 1'b0;
        end else begin
            shadow_l             <= shadow_l_nxt;
            shadow_r             <= shadow_r_nxt;
            channel_status_valid <= complete;
            if (complete) begin
                channel_status_left  <= shadow_l_nxt;
                channel_status_right <= shadow_r_nxt;
            end
        end
    end
`else
    logic unused_cs;
    assign unused_cs            = ^{store, store_idx, complete, c_bit};
    assign channel_status_left  = '0;
    assign channel_status_right = '0;
    assign channel_status_valid = 1'b0;
`endif

endmodule

// File: tb/tb_audio_sample_packet_decoder.sv
// Scoreboard bench for audio_sample_packet_decoder; works with or without AUDIO_CHANNEL_STATUS_EN.

module tb_audio_sample_packet_decoder;
    localparam int L = 192;
`ifdef AUDIO_CHANNEL_STATUS_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic             clk_packet = 1'b0;
    logic             reset_n = 1'b1;
    logic             packet_valid = 1'b0;
    logic [23:0]      header = '0;
    logic [55:0]      sub0 = '0;
    logic             sample_valid, locked, sync_error, channel_status_valid;
    logic [1:0][23:0] audio_sample_word;
    logic [1:0]       valid_bit, user_data_bit, parity_error;
    logic [L-1:0]     channel_status_left, channel_status_right;

    audio_sample_packet_decoder #(.CHANNEL_STATUS_LENGTH(L)) dut (
        .clk_packet           (clk_packet),
        .reset_n              (reset_n),
        .packet_valid         (packet_valid),
        .header               (header),
        .sub0                 (sub0),
        .sample_valid         (sample_valid),
        .audio_sample_word    (audio_sample_word),
        .valid_bit            (valid_bit),
        .user_data_bit        (user_data_bit),
        .parity_error         (parity_error),
        .locked               (locked),
        .sync_error           (sync_error),
        .channel_status_left  (channel_status_left),
        .channel_status_right (channel_status_right),
        .channel_status_valid (channel_status_valid)
    );

    always #5 clk_packet = ~clk_packet;

    typedef struct {
        logic [23:0] l, r;
        logic [1:0]  v, u, par;
        logic        sync, csv, lk;
        logic [L-1:0] csl, csr;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]   pat_l = 8'hA5;
    logic [7:0]   pat_r = 8'h3C;
    bit           m_locked = 1'b0;
    int           m_cnt = 0;
    logic [L-1:0] m_sh_l = '0, m_sh_r = '0, m_cs_l = '0, m_cs_r = '0;

    task automatic chk(input string nm, input logic [L-1:0] act, input logic [L-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] mk_hdr(input logic b);
        return 24'h000102 | {3'b0, b, 20'h0};
    endfunction

    function automatic logic [55:0] mk_sub(input logic [23:0] l, r,
                                           input logic vl, ul, cl, vr, ur, cr,
                                           input logic [1:0] flip);
        logic pl, pr;
        pl = ^{l, vl, ul, cl} ^ flip[0];
        pr = ^{r, vr, ur, cr} ^ flip[1];
        return {pr, cr, ur, vr, pl, cl, ul, vl, r, l};
    endfunction

    // Drives one packet; for accepted packets the block-sync model predicts the response.
    task automatic send(input logic [23:0] hdr, input logic [55:0] sub, input logic [1:0] par);
        exp_t e;
        logic b, cl, cr;
        @(negedge clk_packet);
        packet_valid = 1'b1;
        header = hdr;
        sub0 = sub;
        b  = hdr[20];
        cl = sub[50];
        cr = sub[54];
        if (hdr[7:0] == 8'd2 && !hdr[12] && hdr[8]) begin
            e.l = sub[23:0];
            e.r = sub[47:24];
            e.v = {sub[52], sub[48]};
            e.u = {sub[53], sub[49]};
            e.par = par;
            e.sync = 1'b0;
            e.csv = 1'b0;
            if (!m_locked) begin
                if (b) begin
                    m_sh_l[0] = cl; m_sh_r[0] = cr; m_cnt = 1; m_locked = 1'b1;
                end
            end else if (b && m_cnt != 0) begin
                e.sync = 1'b1;
                m_sh_l[0] = cl; m_sh_r[0] = cr; m_cnt = 1;
            end else if (!b && m_cnt == 0) begin
                e.sync = 1'b1;
                m_locked = 1'b0;
            end else begin
                m_sh_l[m_cnt] = cl; m_sh_r[m_cnt] = cr;
                if (m_cnt == L - 1) begin
                    m_cs_l = m_sh_l; m_cs_r = m_sh_r; e.csv = CS_EN; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            e.lk  = m_locked;
            e.csl = CS_EN ? m_cs_l : '0;
            e.csr = CS_EN ? m_cs_r : '0;
            q.push_back(e);
        end
    endtask

    task automatic frame(input logic b, input int fi, input logic [31:0] seed);
        logic [23:0] l;
        l = 24'(seed * 32'h0001_0203 + 32'h00A5_0001);
        send(mk_hdr(b), mk_sub(l, ~l, seed[0], seed[1], pat_l[fi % 8],
                               seed[2], seed[3], pat_r[fi % 8], 2'b00), 2'b00);
    endtask

    task automatic idle();
        @(negedge clk_packet);
        packet_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sv"},   sample_valid, '0);
        chk({tag, "_word"}, audio_sample_word, '0);
        chk({tag, "_v"},    valid_bit, '0);
        chk({tag, "_u"},    user_data_bit, '0);
        chk({tag, "_par"},  parity_error, '0);
        chk({tag, "_lock"}, locked, '0);
        chk({tag, "_sync"}, sync_error, '0);
        chk({tag, "_csl"},  channel_status_left, '0);
        chk({tag, "_csr"},  channel_status_right, '0);
        chk({tag, "_csv"},  channel_status_valid, '0);
    endtask

    task automatic model_reset();
        m_locked = 1'b0; m_cnt = 0;
        m_sh_l = '0; m_sh_r = '0; m_cs_l = '0; m_cs_r = '0;
    endtask

    // Monitor: pops one expectation per sample_valid pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_packet);
            if (reset_n) begin
                if (sample_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_sample", sample_valid, '0);
                    end else begin
                        e = q.pop_front();
                        chk("word_l", audio_sample_word[0], e.l);
                        chk("word_r", audio_sample_word[1], e.r);
                        chk("valid_bit", valid_bit, e.v);
                        chk("user_bit", user_data_bit, e.u);
                        chk("parity", parity_error, e.par);
                        chk("sync_error", sync_error, e.sync);
                        chk("locked", locked, e.lk);
                        chk("cs_valid", channel_status_valid, e.csv);
                        chk("cs_left", channel_status_left, e.csl);
                        chk("cs_right", channel_status_right, e.csr);
                    end
                end else begin
                    chk("stray_sync", sync_error, '0);
                    chk("stray_csv", channel_status_valid, '0);
                end
            end
        end
    end

    initial begin
        logic [L-1:0] blk_l, blk_r;
        blk_l = CS_EN ? {24{8'hA5}} : '0;
        blk_r = CS_EN ? {24{8'h3C}} : '0;

        #1 reset_n = 1'b0;
        #2 chk_all_zero("reset");
        repeat (2) @(negedge clk_packet);
        reset_n = 1'b1;

        // Full block, B on first frame.
        for (int k = 0; k < L; k++) frame(k == 0, k, k + 1);
        idle(); idle();
        chk("blk1_locked", locked, 1);
        chk("blk1_cs_left", channel_status_left, blk_l);
        chk("blk1_cs_right", channel_status_right, blk_r);

        // Fixed words, correct parity then right parity flipped.
        send(mk_hdr(1'b1), mk_sub(24'h123456, 24'hABCDEF, 1'b0, 1'b0, pat_l[0],
                                  1'b0, 1'b0, pat_r[0], 2'b00), 2'b00);
        send(mk_hdr(1'b0), mk_sub(24'h123456, 24'hABCDEF, 1'b0, 1'b0, pat_l[1],
                                  1'b0, 1'b0, pat_r[1], 2'b10), 2'b10);
        idle();
        chk("par_flip_direct", parity_error, 2'b10);
        chk("word_direct", audio_sample_word, {24'hABCDEF, 24'h123456});

        // Early B at frame 50, ignored packets mixed into the restarted block.
        for (int k = 2; k < 50; k++) frame(1'b0, k, k);
        frame(1'b1, 0, 500);
        for (int k = 1; k < L; k++) begin
            if (k == 60) begin
                send(24'h100101, 56'hFF_FFFF_FFFF_FFFF, 2'b00);
                send(24'h101102, 56'hFF_FFFF_FFFF_FFFF, 2'b00);
                send(24'h100002, 56'hFF_FFFF_FFFF_FFFF, 2'b00);
            end
            frame(1'b0, k, k + 7);
        end
        idle(); idle();
        chk("blk2_cs_left", channel_status_left, blk_l);

        // Missing B after wrap: lose lock, B=0 frames in HUNT, then relock.
        frame(1'b0, 0, 9);
        for (int k = 0; k < 3; k++) frame(1'b0, k, 20 + k);
        idle();
        chk("hunt_locked", locked, 0);
        frame(1'b1, 0, 33);
        for (int k = 1; k < 100; k++) frame(1'b0, k, k + 40);

        // Asynchronous reset at frame 100, away from any clock edge.
        @(negedge clk_packet);
        packet_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk_all_zero("midreset");
        model_reset();
        repeat (2) @(negedge clk_packet);
        reset_n = 1'b1;

        frame(1'b0, 0, 77);
        frame(1'b1, 0, 78);
        for (int k = 1; k < L; k++) frame(1'b0, k, k + 90);
        idle(); idle();
        chk("blk3_cs_right", channel_status_right, blk_r);

        repeat (4) @(negedge clk_packet);
        chk("queue_drained", L'(q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
